sr_cmd_gen: RTL and testbench
=============================

// Module: sr_cmd_gen
// PURPOSE
//  Upstream command stage for the sr_ff block. Takes two raw asynchronous
//  push-button levels (set, clear) and conditions each one: 2-FF synchroniser,
//  then debounce, then rising-edge detect. Drives single-cycle set/reset
//  command pulses (cmd_s -> sr_ff.din_s, cmd_r -> sr_ff.din_r).
//  Guarantees the sr_ff never sees S=R=1 in the same cycle.
// PARAMETERS
//  DEBOUNCE_CYC  16  cycles a synchronised input must hold a new level before
//                    it is accepted (>=2); a value of 4 is used in simulation
//  CNT_W         $clog2(DEBOUNCE_CYC+1)  debounce counter width (derived)
// PORTS
//  clk        in   1  rising-edge clock, single clock domain
//  rst        in   1  asynchronous active-high reset
//  btn_set    in   1  raw set button level, asynchronous, may bounce
//  btn_clr    in   1  raw clear button level, asynchronous, may bounce
//  cmd_s      out  1  one-cycle set pulse to the sr_ff din_s input
//  cmd_r      out  1  one-cycle reset pulse to the sr_ff din_r input
//  lvl_set    out  1  debounced set level (status)
//  lvl_clr    out  1  debounced clear level (status)
//  conflict   out  1  one-cycle pulse: both edges accepted in the same cycle
// BEHAVIOUR
//  - Reset (async assert, released synchronously by the flops):
//    - all outputs 0; sync flops 0; counters 0; both channel FSMs in S_LOW.
//  - Sync: 2 flops per input; sync_x is the second stage. No logic on stage 1.
//  - Channel FSM (per input, states S_LOW, S_RISE, S_HIGH, S_FALL):
//    - S_LOW : sync_x=1 -> S_RISE, cnt<=1; else stay, cnt<=0.
//    - S_RISE: sync_x=0 -> S_LOW, cnt<=0 (glitch rejected).
//              cnt==DEBOUNCE_CYC-1 and sync_x=1 -> S_HIGH, edge_x=1 for 1 cycle.
//              otherwise cnt<=cnt+1.
//    - S_HIGH: sync_x=0 -> S_FALL, cnt<=1; else stay.
//    - S_FALL: sync_x=1 -> S_HIGH, cnt<=0.
//              cnt==DEBOUNCE_CYC-1 and sync_x=0 -> S_LOW (no pulse on release).
//              otherwise cnt<=cnt+1.
//    - lvl_x=1 in S_HIGH and S_FALL; 0 in S_LOW and S_RISE.
//  - Counter: saturating, never wraps. Cleared on every state change back.
//  - Latency: raw input rises before clock edge E0 and stays stable.
//    - sync_x goes high after E1.
//    - The FSM enters S_HIGH at edge E1+DEBOUNCE_CYC.
//    - cmd_x (registered) is high for exactly the cycle after edge
//      E2+DEBOUNCE_CYC.
//  - Each accepted press gives exactly 1 pulse, however long it is held.
//  - Arbitration (registered output stage):
//    - edge_s & ~edge_r -> cmd_s=1
//    - edge_r & ~edge_s -> cmd_r=1
//    - edge_s & edge_r  -> cmd_s=0, cmd_r=0, conflict=1 (both suppressed)
//    - cmd_s and cmd_r are never high together.
//  - Reset mid-debounce: in-flight counts and pending pulses are lost.
//    A button still held at reset release needs a full DEBOUNCE_CYC from
//    S_LOW before it is accepted.
// STRUCTURE
//  - sr_cmd_pkg: channel state localparams S_LOW=2'd0, S_RISE=2'd1,
//    S_HIGH=2'd2, S_FALL=2'd3; default DEBOUNCE_CYC.
//  - Sub-module sr_debounce_ch: sync + counter + FSM + edge. Ports: clk, rst,
//    btn, lvl, edge. Instantiated twice.
//  - The top level holds only the arbitration flops and output registers.
// TESTING (DEBOUNCE_CYC=4, T_CLK=10ns)
//  1 reset: rst=1 with btn_set=1 -> all outputs 0; release rst -> cmd_s
//    pulses once, 6 cycles after the first edge following release.
//  2 clean press: btn_set 0->1, held 20 cycles -> exactly one cmd_s pulse;
//    lvl_set=1 from the same cycle until 6 cycles after release.
//  3 bounce: btn_clr toggled 1,0,1,0 with each level held 2 cycles, then held
//    high -> no pulse during toggling; one cmd_r pulse 4 cycles after the
//    level becomes stable in sync.
//  4 glitch on release: held-high btn_set drops for 2 cycles -> lvl_set stays 1;
//    a later re-press gives no extra pulse.
//  5 simultaneous: btn_set and btn_clr rise at the same edge -> conflict=1 for
//    1 cycle; cmd_s=cmd_r=0.
//    Offset by 1 cycle -> cmd_s then cmd_r in consecutive cycles, conflict=0.
//  6 chain with sr_ff: set press -> dout_q=1; clear press -> dout_q=0; a held
//    button never retoggles the output.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: debounce channel state encoding and default debounce length shared by sr_cmd_gen and sr_debounce_ch
package sr_cmd_pkg;
  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } ch_state_e;
  localparam int DEBOUNCE_CYC_DEF = 16;
endpackage

// File: rtl/sr_debounce_ch.sv
// sr_debounce_ch: 2-FF sync, debounce FSM and rising-edge pulse; clk/rst, btn_i raw level in, lvl_o debounced level, edge_o one-cycle pulse on accepted press
module sr_debounce_ch
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic lvl_o,
  output logic edge_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);
  logic [1:0] sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  ch_state_e state_q;
  logic edge_q;
  logic sync_x;
  assign sync_x = sync_q[1];
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      state_q <= S_LOW;
      edge_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      edge_q <= 1'b0;
      case (state_q)
        S_LOW: begin
          state_q <= sync_x ? S_RISE : S_LOW;
          cnt_q   <= sync_x ? CNT_W'(1) : '0;
        end
        S_RISE:
          if (!sync_x) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
            edge_q  <= 1'b1;
          end else
            cnt_q <= cnt_inc;
        S_HIGH: begin
          state_q <= sync_x ? S_HIGH : S_FALL;
          cnt_q   <= sync_x ? '0 : CNT_W'(1);
        end
        S_FALL:
          if (sync_x) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
          end else
            cnt_q <= cnt_inc;
      endcase
    end
  assign lvl_o  = (state_q == S_HIGH) || (state_q == S_FALL);
  assign edge_o = edge_q;
endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounced set/clear command pulses for sr_ff; clk/rst, btn_set/btn_clr raw in, cmd_s/cmd_r pulses, lvl_set/lvl_clr levels, conflict when both edges coincide
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_clr,
  output logic cmd_s,
  output logic cmd_r,
  output logic lvl_set,
  output logic lvl_clr,
  output logic conflict
);
  logic edge_s, edge_r, lvl_s, lvl_r;
  sr_debounce_ch #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_set (
    .clk(clk), .rst(rst), .btn_i(btn_set), .lvl_o(lvl_s), .edge_o(edge_s)
  );
  sr_debounce_ch #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clr (
    .clk(clk), .rst(rst), .btn_i(btn_clr), .lvl_o(lvl_r), .edge_o(edge_r)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmd_s    <= 1'b0;
      cmd_r    <= 1'b0;
      conflict <= 1'b0;
      lvl_set  <= 1'b0;
      lvl_clr  <= 1'b0;
    end else begin
      cmd_s    <= edge_s & ~edge_r;
      cmd_r    <= edge_r & ~edge_s;
      conflict <= edge_s & edge_r;
      lvl_set  <= lvl_s;
      lvl_clr  <= lvl_r;
    end
endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: self-checking bench for sr_cmd_gen with a run-length debounce model and directed scenarios
module tb_sr_cmd_gen;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b1, btn_set = 1'b0, btn_clr = 1'b0;
  logic cmd_s, cmd_r, lvl_set, lvl_clr, conflict;
  int checks = 0, errors = 0;
  int cyc = 0;
  sr_cmd_gen #(.DEBOUNCE_CYC(D)) dut (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_clr(btn_clr),
    .cmd_s(cmd_s), .cmd_r(cmd_r), .lvl_set(lvl_set), .lvl_clr(lvl_clr), .conflict(conflict)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  logic [1:0] h1 = '0, h2 = '0, sy = '0, lvl_m = '0, ev_m = '0, e_lvl = '0;
  logic e_cs = 1'b0, e_cr = 1'b0, e_cf = 1'b0;
  int run_m [2] = '{0, 0};
  always @(posedge clk or posedge rst)
    if (rst) begin
      h1 = '0; h2 = '0; lvl_m = '0; ev_m = '0; e_lvl = '0;
      e_cs = 1'b0; e_cr = 1'b0; e_cf = 1'b0; run_m = '{0, 0};
    end else begin
      e_cs = ev_m[0] & ~ev_m[1];
      e_cr = ev_m[1] & ~ev_m[0];
      e_cf = ev_m[0] & ev_m[1];
      e_lvl = lvl_m;
      sy = h2;
      h2 = h1;
      h1 = {btn_clr, btn_set};
      for (int i = 0; i < 2; i++) begin
        ev_m[i] = 1'b0;
        if (sy[i] != lvl_m[i]) begin
          run_m[i]++;
          if (run_m[i] == D) begin
            lvl_m[i] = sy[i];
            ev_m[i]  = sy[i];
            run_m[i] = 0;
          end
        end else run_m[i] = 0;
      end
    end
  task automatic chk(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b at cycle %0d", n, a, e, cyc);
    end
  endtask
  task automatic chk_int(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  int n_s = 0, n_r = 0, n_cf = 0, last_s = -1, last_r = -1, last_cf = -1;
  int rise_ls = -1, fall_ls = -1, n_fall_ls = 0;
  logic p_ls = 1'b0;
  always @(posedge clk) begin
    #1;
    chk("cmd_s", cmd_s, e_cs);
    chk("cmd_r", cmd_r, e_cr);
    chk("conflict", conflict, e_cf);
    chk("lvl_set", lvl_set, e_lvl[0]);
    chk("lvl_clr", lvl_clr, e_lvl[1]);
    chk("cmd_excl", cmd_s & cmd_r, 1'b0);
    if (cmd_s === 1'b1) begin n_s++; last_s = cyc; end
    if (cmd_r === 1'b1) begin n_r++; last_r = cyc; end
    if (conflict === 1'b1) begin n_cf++; last_cf = cyc; end
    if (lvl_set === 1'b1 && !p_ls) rise_ls = cyc;
    if (lvl_set === 1'b0 && p_ls) begin fall_ls = cyc; n_fall_ls++; end
    p_ls = (lvl_set === 1'b1);
  end
  logic dout_q = 1'b0;
  always @(posedge clk)
    if (cmd_s) dout_q <= 1'b1;
    else if (cmd_r) dout_q <= 1'b0;
  int t, n0, r0, c0, f0;
  logic [7:0] bounce;
  initial begin
    rst = 1'b1;
    btn_set = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_s", cmd_s, 1'b0);
    chk("rst_cmd_r", cmd_r, 1'b0);
    chk("rst_conflict", conflict, 1'b0);
    chk("rst_lvl_set", lvl_set, 1'b0);
    chk("rst_lvl_clr", lvl_clr, 1'b0);
    n0 = n_s;
    rst = 1'b0;
    t = cyc + 1;
    repeat (12) @(negedge clk);
    chk_int("t1_pulses", n_s - n0, 1);
    chk_int("t1_when", last_s, t + 6);
    btn_set = 1'b0;
    repeat (12) @(negedge clk);
    n0 = n_s;
    btn_set = 1'b1;
    t = cyc + 1;
    repeat (20) @(negedge clk);
    chk_int("t2_pulses", n_s - n0, 1);
    chk_int("t2_when", last_s, t + 6);
    chk_int("t2_lvl_rise", rise_ls, t + 6);
    btn_set = 1'b0;
    t = cyc + 1;
    repeat (12) @(negedge clk);
    chk_int("t2_lvl_fall", fall_ls, t + 6);
    r0 = n_r;
    bounce = 8'b00110011;
    for (int i = 0; i < 8; i++) begin
      btn_clr = bounce[i];
      @(negedge clk);
    end
    chk_int("t3_no_bounce_pulse", n_r - r0, 0);
    btn_clr = 1'b1;
    t = cyc + 1;
    repeat (14) @(negedge clk);
    chk_int("t3_pulses", n_r - r0, 1);
    chk_int("t3_when", last_r, t + 6);
    btn_clr = 1'b0;
    repeat (12) @(negedge clk);
    btn_set = 1'b1;
    repeat (12) @(negedge clk);
    n0 = n_s;
    f0 = n_fall_ls;
    btn_set = 1'b0;
    repeat (2) @(negedge clk);
    btn_set = 1'b1;
    repeat (15) @(negedge clk);
    chk_int("t4_no_extra_pulse", n_s - n0, 0);
    chk_int("t4_lvl_held", n_fall_ls - f0, 0);
    chk("t4_lvl_now", lvl_set, 1'b1);
    btn_set = 1'b0;
    repeat (12) @(negedge clk);
    n0 = n_s; r0 = n_r; c0 = n_cf;
    btn_set = 1'b1;
    btn_clr = 1'b1;
    t = cyc + 1;
    repeat (12) @(negedge clk);
    chk_int("t5_conflicts", n_cf - c0, 1);
    chk_int("t5_conflict_when", last_cf, t + 6);
    chk_int("t5_no_set", n_s - n0, 0);
    chk_int("t5_no_clr", n_r - r0, 0);
    btn_set = 1'b0;
    btn_clr = 1'b0;
    repeat (12) @(negedge clk);
    n0 = n_s; r0 = n_r; c0 = n_cf;
    btn_set = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    btn_clr = 1'b1;
    repeat (12) @(negedge clk);
    chk_int("t5o_set_when", last_s, t + 6);
    chk_int("t5o_clr_when", last_r, t + 7);
    chk_int("t5o_set_pulses", n_s - n0, 1);
    chk_int("t5o_clr_pulses", n_r - r0, 1);
    chk_int("t5o_no_conflict", n_cf - c0, 0);
    btn_set = 1'b0;
    btn_clr = 1'b0;
    repeat (12) @(negedge clk);
    btn_set = 1'b1;
    repeat (12) @(negedge clk);
    chk("t6_set_dout", dout_q, 1'b1);
    btn_clr = 1'b1;
    repeat (12) @(negedge clk);
    chk("t6_clr_dout", dout_q, 1'b0);
    n0 = n_s;
    repeat (20) @(negedge clk);
    chk("t6_held_dout", dout_q, 1'b0);
    chk_int("t6_no_retoggle", n_s - n0, 0);
    btn_set = 1'b0;
    btn_clr = 1'b0;
    repeat (12) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
